// File: rtl/quad_switch_allocator.sv
// quad_switch_allocator
//   Multicast switch allocator for the 5-port quadtree router
//   (children 0-3 on mask bits 0-3, parent/local on bit 4).
//   Every cycle it picks a conflict-free set of head flits using
//   round-robin priority and drives registered per-input grant/drop pulses
//   plus per-output crossbar valid/select fields.
//
//   Build option: define SA_AGING_EN to add per-input saturating age
//   counters. Inputs whose age reaches STARVE_LIMIT are searched first,
//   ahead of the round-robin rotation. Without the macro, plain round-robin
//   from the pointer is used and the port list is unchanged.
//
//   A granted or dropped input is ineligible for exactly one cycle (the
//   pulse cycle), giving the requester time to present its next flit.
module quad_switch_allocator #(
    parameter int NUM_PORT     = 5,
    parameter int SEL_WIDTH    = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORT-1:0]           req_valid_i,
    input  logic [NUM_PORT*NUM_PORT-1:0]  req_port_i,
    input  logic [NUM_PORT-1:0]           out_ready_i,
    output logic [NUM_PORT-1:0]           grant_o,
    output logic [NUM_PORT-1:0]           drop_o,
    output logic [NUM_PORT-1:0]           out_valid_o,
    output logic [NUM_PORT*SEL_WIDTH-1:0] out_sel_o
);

    localparam int PTR_W = $clog2(NUM_PORT);

    logic [NUM_PORT-1:0]           grant_q,     grant_d;
    logic [NUM_PORT-1:0]           drop_q,      drop_d;
    logic [NUM_PORT-1:0]           out_valid_q, out_valid_d;
    logic [NUM_PORT*SEL_WIDTH-1:0] out_sel_q,   out_sel_d;
    logic [PTR_W-1:0]              ptr_q,       ptr_d;

    logic [NUM_PORT-1:0] mask [NUM_PORT];
    logic [NUM_PORT-1:0] eligible;
    logic [NUM_PORT-1:0] starving;

    // Arbitration scratch variables
    logic [NUM_PORT-1:0] claimed;
    logic                rr_found;
    logic                pass_ok;
    int                  idx;

    // Unpack the per-input route masks
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            mask[i] = req_port_i[i*NUM_PORT +: NUM_PORT];
        end
    end

    // An input sitting in its grant/drop pulse cycle is not eligible
    always_comb begin
        eligible = req_valid_i & ~grant_q & ~drop_q;
    end

`ifdef SA_AGING_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [AGE_W-1:0] age_q [NUM_PORT];
    logic [AGE_W-1:0] age_d [NUM_PORT];

    // Inputs at the age ceiling jump ahead of the rotation
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            starving[i] = (age_q[i] == AGE_W'(STARVE_LIMIT));
        end
    end

    // Age grows while an eligible, routable input loses; it saturates at the limit
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            age_d[i] = age_q[i];
            if (!req_valid_i[i] || grant_d[i] || drop_d[i]) begin
                age_d[i] = '0;
            end else if (eligible[i] && (mask[i] != '0) &&
                         (age_q[i] != AGE_W'(STARVE_LIMIT))) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // Age counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    logic [31:0] unused_starve_limit;

    assign unused_starve_limit = STARVE_LIMIT;

    // No aging: nobody ever jumps the rotation
    always_comb begin
        starving = '0;
    end
`endif

    // Allocation: slots 0..N-1 visit starving inputs in ascending order,
    // slots N..2N-1 visit the remaining inputs in rotation from ptr.
    // A multicast request is granted whole or not at all.
    always_comb begin
        grant_d     = '0;
        drop_d      = '0;
        out_sel_d   = '0;
        ptr_d       = ptr_q;
        claimed     = '0;
        rr_found    = 1'b0;
        pass_ok     = 1'b0;
        idx         = 0;

        for (int i = 0; i < NUM_PORT; i++) begin
            if (eligible[i] && (mask[i] == '0)) begin
                drop_d[i] = 1'b1;
            end
        end

        for (int s = 0; s < 2*NUM_PORT; s++) begin
            if (s < NUM_PORT) begin
                idx     = s;
                pass_ok = starving[idx];
            end else begin
                idx = int'(ptr_q) + s - NUM_PORT;
                if (idx >= NUM_PORT) begin
                    idx = idx - NUM_PORT;
                end
                pass_ok = ~starving[idx];
            end

            if (pass_ok && eligible[idx] && (mask[idx] != '0) &&
                ((mask[idx] & ~out_ready_i) == '0) &&
                ((mask[idx] & claimed) == '0)) begin
                grant_d[idx] = 1'b1;
                claimed      = claimed | mask[idx];
                for (int j = 0; j < NUM_PORT; j++) begin
                    if (mask[idx][j]) begin
                        out_sel_d[j*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(idx);
                    end
                end
                // Only the first rotation-order winner moves the pointer
                if ((s >= NUM_PORT) && !rr_found) begin
                    rr_found = 1'b1;
                    ptr_d    = (idx == NUM_PORT - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end

        out_valid_d = claimed;
    end

    // Output and pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q     <= '0;
            drop_q      <= '0;
            out_valid_q <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            grant_q     <= grant_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant_o     = grant_q;
    assign drop_o      = drop_q;
    assign out_valid_o = out_valid_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_quad_switch_allocator.sv
// Testbench for quad_switch_allocator: directed scenarios with literal
// expectations plus a requester-compliant random phase, all cross-checked
// every cycle against a behavioural allocation model.
module tb_quad_switch_allocator;

    localparam int N     = 5;
    localparam int SW    = 3;
    localparam int LIMIT = 15;
`ifdef SA_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*N-1:0] req_port = '0;
    logic [N-1:0]  out_ready = '1;
    logic [N-1:0]  grant;
    logic [N-1:0]  drop;
    logic [N-1:0]  out_valid;
    logic [N*SW-1:0] out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    quad_switch_allocator #(
        .NUM_PORT     (N),
        .SEL_WIDTH    (SW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_port_i  (req_port),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .drop_o      (drop),
        .out_valid_o (out_valid),
        .out_sel_o   (out_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr = 0;
    int          m_age [N];
    logic [N-1:0] m_grant = '0;
    logic [N-1:0] m_drop  = '0;
    logic [N-1:0] m_valid = '0;
    logic [N*SW-1:0] m_sel = '0;

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_grant = '0;
        m_drop  = '0;
        m_valid = '0;
        m_sel   = '0;
    endtask

    task automatic model_step();
        int           order[$];
        int           nst;
        int           first_rr;
        int           who;
        logic [N-1:0] msk;
        logic [N-1:0] ng, nd, cl;
        logic [N*SW-1:0] ns;
        bit           elig [N];
        ng = '0; nd = '0; cl = '0; ns = '0; first_rr = -1;
        for (int i = 0; i < N; i++)
            elig[i] = req_valid[i] && !m_grant[i] && !m_drop[i];
        for (int i = 0; i < N; i++)
            if (AGING && m_age[i] == LIMIT) order.push_back(i);
        nst = order.size();
        for (int k = 0; k < N; k++) begin
            who = (m_ptr + k) % N;
            if (!(AGING && m_age[who] == LIMIT)) order.push_back(who);
        end
        for (int n = 0; n < order.size(); n++) begin
            who = order[n];
            msk = req_port[who*N +: N];
            if (elig[who]) begin
                if (msk == '0) nd[who] = 1'b1;
                else if (((msk & ~out_ready) == '0) && ((msk & cl) == '0)) begin
                    ng[who] = 1'b1;
                    cl = cl | msk;
                    for (int j = 0; j < N; j++)
                        if (msk[j]) ns[j*SW +: SW] = 3'(who);
                    if (n >= nst && first_rr < 0) first_rr = who;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            msk = req_port[i*N +: N];
            if (!req_valid[i] || ng[i] || nd[i]) m_age[i] = 0;
            else if (elig[i] && msk != '0 && m_age[i] < LIMIT) m_age[i] = m_age[i] + 1;
        end
        if (first_rr >= 0) m_ptr = (first_rr + 1) % N;
        m_grant = ng;
        m_drop  = nd;
        m_valid = cl;
        m_sel   = ns;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        chk("model_grant",     32'(grant),     32'(m_grant));
        chk("model_drop",      32'(drop),      32'(m_drop));
        chk("model_out_valid", 32'(out_valid), 32'(m_valid));
        chk("model_out_sel",   32'(out_sel),   32'(m_sel));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int i, input logic [N-1:0] m);
        req_port[i*N +: N] = m;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_port  = '0;
        out_ready = '1;
        #1 rst = 1'b1;
        #1;
        chk("rst_grant",     32'(grant),     0);
        chk("rst_drop",      32'(drop),      0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel",   32'(out_sel),   0);
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0] rm;
    bit           found;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single unicast, then blank cycle while held
        req_valid = 5'b00001;
        set_mask(0, 5'b00010);
        step();
        chk("single_grant",     32'(grant),        32'b00001);
        chk("single_out_valid", 32'(out_valid),    32'b00010);
        chk("single_sel1",      32'(out_sel[5:3]), 0);
        step();
        chk("single_blank_grant", 32'(grant),     0);
        chk("single_blank_valid", 32'(out_valid), 0);
        req_valid = '0;
        step();

        // three-way conflict on output 4, then ptr=3 check
        do_reset();
        req_valid = 5'b00111;
        set_mask(0, 5'b10000);
        set_mask(1, 5'b10000);
        set_mask(2, 5'b10000);
        step();
        chk("conf_g0",   32'(grant),          32'b00001);
        chk("conf_v0",   32'(out_valid),      32'b10000);
        chk("conf_s0",   32'(out_sel[14:12]), 0);
        req_valid = 5'b00110;
        step();
        chk("conf_g1",   32'(grant),          32'b00010);
        chk("conf_s1",   32'(out_sel[14:12]), 1);
        req_valid = 5'b00100;
        step();
        chk("conf_g2",   32'(grant),          32'b00100);
        chk("conf_s2",   32'(out_sel[14:12]), 2);
        req_valid = '0;
        step();
        req_valid = 5'b01001;
        set_mask(3, 5'b10000);
        step();
        chk("conf_ptr3", 32'(grant), 32'b01000);
        req_valid = '0;
        step();

        // multicast atomicity
        do_reset();
        req_valid = 5'b10000;
        set_mask(4, 5'b01111);
        out_ready = 5'b01110;
        step();
        chk("mc_blocked_grant", 32'(grant),     0);
        chk("mc_blocked_valid", 32'(out_valid), 0);
        out_ready = 5'b11111;
        step();
        chk("mc_grant", 32'(grant),     32'b10000);
        chk("mc_valid", 32'(out_valid), 32'b01111);
        chk("mc_sel",   32'(out_sel),   32'(15'b000_100_100_100_100));
        req_valid = '0;
        step();

        // disjoint parallel grants, then reset mid-operation
        do_reset();
        set_mask(0, 5'b00010);
        set_mask(1, 5'b00100);
        set_mask(2, 5'b01000);
        set_mask(3, 5'b00001);
        req_valid = 5'b01111;
        step();
        chk("par_grant", 32'(grant),     32'b01111);
        chk("par_valid", 32'(out_valid), 32'b01111);
        chk("par_sel",   32'(out_sel),   32'(15'b000_010_001_000_011));
        do_reset();

        // zero mask drop, ptr must stay at 0
        req_valid = 5'b01000;
        set_mask(3, 5'b00000);
        step();
        chk("zm_drop",  32'(drop),      32'b01000);
        chk("zm_grant", 32'(grant),     0);
        chk("zm_valid", 32'(out_valid), 0);
        req_valid = 5'b10001;
        set_mask(0, 5'b10000);
        set_mask(4, 5'b10000);
        step();
        chk("zm_ptr_hold", 32'(grant), 32'b00001);
        req_valid = '0;
        step();

        // starvation via blocked output, then release against a rival
        do_reset();
        req_valid = 5'b00100;
        set_mask(2, 5'b00001);
        out_ready = 5'b11110;
        repeat (LIMIT + 2) step();
        chk("age_blocked", 32'(grant), 0);
        out_ready = 5'b11111;
        req_valid = 5'b00101;
        set_mask(0, 5'b00001);
        step();
        if (AGING) begin
            chk("age_starve_first", 32'(grant), 32'b00100);
            req_valid = 5'b10001;
            set_mask(4, 5'b00001);
            step();
            chk("age_ptr_hold", 32'(grant), 32'b00001);
        end else begin
            chk("rr_first", 32'(grant), 32'b00001);
            req_valid = 5'b00100;
            step();
            chk("rr_second", 32'(grant), 32'b00100);
        end
        req_valid = '0;
        step();

        // inputs 0/1 stream continuously; input 2 must win within the bound
        do_reset();
        set_mask(0, 5'b00001);
        set_mask(1, 5'b00001);
        set_mask(2, 5'b00001);
        req_valid = 5'b00111;
        found = 1'b0;
        for (int c = 0; c < LIMIT + 2 && !found; c++) begin
            step();
            if (grant[2]) found = 1'b1;
        end
        chk("age_bound", 32'(found), 1);
        req_valid = '0;
        step();

        // random requester-compliant traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || grant[i] || drop[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    rm = 5'($urandom_range(0, 31));
                    if ($urandom_range(0, 7) == 0) rm = '0;
                    set_mask(i, rm);
                end
            end
            out_ready = 5'($urandom) | 5'($urandom);
            step();
        end
        req_valid = '0;
        step();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
